// File: rtl/seq_ceil_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, floor or ceil quotient
// plus floor remainder, with a valid/ready request and response handshake.
module seq_ceil_divider #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             ceil_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ceil_q;
  logic             dz_q;

  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_dq;
  logic             round_up;
  logic [WIDTH-1:0] final_quo;

  assign accept    = req_valid_i && req_ready_o;
  assign last_step = (cnt_q == '0);

  // One restoring step; the shifted value carries an extra bit so the compare cannot wrap
  always_comb begin
    shifted   = {rem_q, dq_q[WIDTH-1]};
    fits      = (shifted >= {1'b0, dvs_q});
    diff      = shifted[WIDTH-1:0] - dvs_q;
    next_rem  = fits ? diff : shifted[WIDTH-1:0];
    next_dq   = {dq_q[WIDTH-2:0], fits};
    round_up  = ceil_q && (next_rem != '0);
    final_quo = next_dq + {{(WIDTH-1){1'b0}}, round_up};
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)      state_d = ST_CALC;
      ST_CALC: if (last_step)   state_d = ST_DONE;
      ST_DONE: if (rsp_ready_i) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    rsp_valid_o = (state_q == ST_DONE);
  end

  // A zero divisor still passes through CALC for exactly one step so its response
  // appears one cycle after acceptance, without running the subtract loop.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      dq_q        <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      ceil_q      <= 1'b0;
      dz_q        <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            dq_q   <= dividend_i;
            dvs_q  <= divisor_i;
            ceil_q <= ceil_i;
            rem_q  <= '0;
            dz_q   <= (divisor_i == '0);
            cnt_q  <= (divisor_i == '0) ? '0 : CNT_W'(WIDTH - 1);
          end
        end
        ST_CALC: begin
          if (!last_step) begin
            cnt_q <= cnt_q - 1'b1;
          end
          if (dz_q) begin
            quotient_o  <= '1;
            remainder_o <= dq_q;
            div_zero_o  <= 1'b1;
          end else begin
            rem_q <= next_rem;
            dq_q  <= next_dq;
            if (last_step) begin
              quotient_o  <= final_quo;
              remainder_o <= next_rem;
              div_zero_o  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
